// File: rtl/episode_pkg.sv
// Shared types and constants for the episode sequencer and its comparator.
package episode_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        DONE    = 2'b10,
        RESTART = 2'b11
    } state_t;

    // Reason an episode ended, reported on done_cause.
    localparam logic [1:0] GOAL  = 2'b00;
    localparam logic [1:0] LIMIT = 2'b01;
    localparam logic [1:0] ABORT = 2'b10;

    // Step-limit termination value, shared with the comparator.
    localparam int MAX_STEPS = 25;

endpackage

// File: rtl/episode_controller_if.sv
// Bundle of control, step handshake and status signals of the episode controller.
// Step handshake: a step transfers on a rising clk edge where step_valid and
// step_ready are both high; step_ready is only ever high in RUN, and a step
// presented in any other state is never acknowledged.
interface episode_controller_if #(
    parameter int REWARD_LENGTH  = 10,
    parameter int STEP_LENGTH    = 5,
    parameter int EPISODE_LENGTH = 16
);
    logic                      start;
    logic                      select;
    logic                      auto_restart;
    logic                      abort;
    logic                      step_valid;
    logic [REWARD_LENGTH-1:0]  reward_in;
    logic                      step_ready;
    logic [STEP_LENGTH-1:0]    step_count;
    logic [REWARD_LENGTH-1:0]  reward;
    logic                      episode_done;
    logic [1:0]                done_cause;
    logic                      agent_reset;
    logic [EPISODE_LENGTH-1:0] episode_count;
    logic                      busy;

    // Agent / host side.
    modport master (
        output start, select, auto_restart, abort, step_valid, reward_in,
        input  step_ready, step_count, reward, episode_done, done_cause,
               agent_reset, episode_count, busy
    );

    // Controller side.
    modport slave (
        input  start, select, auto_restart, abort, step_valid, reward_in,
        output step_ready, step_count, reward, episode_done, done_cause,
               agent_reset, episode_count, busy
    );
endinterface

// File: rtl/episode_controller_cmp.sv
// Termination comparator: step mode fires when the next step count reaches
// MAX_STEPS, goal mode fires when the reward is all-ones.
module is_equal_1023
    import episode_pkg::*;
#(
    parameter int REWARD_LENGTH = 10,
    parameter int STEP_LENGTH   = 5
) (
    input  logic [REWARD_LENGTH-1:0] reward,
    input  logic [STEP_LENGTH-1:0]   step_count,
    input  logic                     select,
    output logic                     terminate
);
    assign terminate = select ? (step_count == STEP_LENGTH'(MAX_STEPS))
                              : (&reward);
endmodule

// File: rtl/episode_controller.sv
// Episode sequencer: accepts agent steps, counts them, keeps the latest reward,
// ends episodes on goal, step limit or abort, and optionally restarts.
// All outputs are registered; each is computed from the next-state values.
module episode_controller
    import episode_pkg::*;
#(
    parameter int REWARD_LENGTH  = 10,
    parameter int STEP_LENGTH    = 5,
    parameter int EPISODE_LENGTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    episode_controller_if.slave  bus,
    output state_t               fsm_state
);
    state_t                    state, state_d;
    logic                      mode, mode_d;
    logic [STEP_LENGTH-1:0]    step_count_q, step_count_d;
    logic [REWARD_LENGTH-1:0]  reward_q, reward_d;
    logic [1:0]                cause_q, cause_d;
    logic [EPISODE_LENGTH-1:0] episode_count_q, episode_count_d;
    logic                      step_ready_q, busy_q, episode_done_q, agent_reset_q;

    logic                      accept;
    logic                      terminate;
    logic [STEP_LENGTH-1:0]    step_next;

    // Step count after this step; held at all-ones so goal mode never wraps.
    assign step_next = (&step_count_q) ? step_count_q : step_count_q + STEP_LENGTH'(1);
    assign accept    = step_ready_q && bus.step_valid;

    is_equal_1023 #(
        .REWARD_LENGTH (REWARD_LENGTH),
        .STEP_LENGTH   (STEP_LENGTH)
    ) u_cmp (
        .reward     (bus.reward_in),
        .step_count (step_next),
        .select     (mode),
        .terminate  (terminate)
    );

    // Next-state, counter and cause logic.
    always_comb begin
        state_d         = state;
        mode_d          = mode;
        step_count_d    = step_count_q;
        reward_d        = reward_q;
        cause_d         = cause_q;
        episode_count_d = episode_count_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d      = RUN;
                    mode_d       = bus.select;
                    step_count_d = '0;
                    reward_d     = '0;
                    cause_d      = GOAL;
                end
            end
            RUN: begin
                if (accept) begin
                    step_count_d = step_next;
                    reward_d     = bus.reward_in;
                end
                // A terminating step outranks a simultaneous abort.
                if (accept && terminate) begin
                    state_d = DONE;
                    cause_d = mode ? LIMIT : GOAL;
                end else if (bus.abort) begin
                    state_d = DONE;
                    cause_d = ABORT;
                end
                if (state_d == DONE) begin
                    episode_count_d = episode_count_q + EPISODE_LENGTH'(1);
                end
            end
            DONE: begin
                state_d      = RESTART;
                step_count_d = '0;
                reward_d     = '0;
            end
            RESTART: begin
                state_d = bus.auto_restart ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            mode            <= 1'b0;
            step_count_q    <= '0;
            reward_q        <= '0;
            cause_q         <= GOAL;
            episode_count_q <= '0;
            step_ready_q    <= 1'b0;
            busy_q          <= 1'b0;
            episode_done_q  <= 1'b0;
            agent_reset_q   <= 1'b0;
        end else begin
            state           <= state_d;
            mode            <= mode_d;
            step_count_q    <= step_count_d;
            reward_q        <= reward_d;
            cause_q         <= cause_d;
            episode_count_q <= episode_count_d;
            step_ready_q    <= (state_d == RUN);
            busy_q          <= (state_d != IDLE);
            episode_done_q  <= (state_d == DONE);
            agent_reset_q   <= (state_d == RESTART);
        end
    end

    assign bus.step_ready    = step_ready_q;
    assign bus.step_count    = step_count_q;
    assign bus.reward        = reward_q;
    assign bus.episode_done  = episode_done_q;
    assign bus.done_cause    = cause_q;
    assign bus.agent_reset   = agent_reset_q;
    assign bus.episode_count = episode_count_q;
    assign bus.busy          = busy_q;
    assign fsm_state         = state;

endmodule

// File: tb/tb_episode_controller.sv
// Bench for episode_controller: table of whole episodes checked through an
// expected-result queue, plus hand-written corner sequences.
module tb_episode_controller;
    import episode_pkg::*;

    localparam int W = 17;  // {done_cause, step_count, reward}

    logic clk;
    logic rst_n;
    state_t dbg_state, dbg_state2;

    episode_controller_if bus ();
    episode_controller_if #(.EPISODE_LENGTH(2)) bus2 ();

    episode_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .fsm_state (dbg_state)
    );

    episode_controller #(.EPISODE_LENGTH(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus2.slave),
        .fsm_state (dbg_state2)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        int         n;
        logic [9:0] rew;
        logic [9:0] last;
        bit         abort;
        logic [1:0] cause;
        logic [4:0] steps;
        logic [9:0] rew_exp;
    } vec_t;

    vec_t           tbl [8];
    logic [W-1:0]   exp_q [$];
    int             total = 0;
    int             bad = 0;
    int             ep_model = 0;
    logic           prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; sample after the edge and score any finished episode.
    task automatic cycle();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (prev_done || bus.agent_reset)
            check("agent_reset_follows_done", 32'(bus.agent_reset), 32'(prev_done));
        if (bus.episode_done) begin
            ep_model++;
            check("episode_count", 32'(bus.episode_count), 32'(ep_model[15:0]));
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_cause", 32'(bus.done_cause), 32'(e[16:15]));
                check("done_steps", 32'(bus.step_count), 32'(e[14:10]));
                check("done_reward", 32'(bus.reward), 32'(e[9:0]));
            end
        end
        prev_done = bus.episode_done;
    endtask

    // Present one step and hold it until it is accepted.
    task automatic drive_step(input logic [9:0] r);
        int guard;
        guard = 0;
        bus.step_valid = 1'b1;
        bus.reward_in  = r;
        while (bus.step_ready !== 1'b1 && guard < 20) begin
            cycle();
            guard++;
        end
        if (guard >= 20) check("step_ready_timeout", 32'(bus.step_ready), 32'd1);
        cycle();
    endtask

    task automatic start_episode(input logic sel);
        bus.select = sel;
        bus.start  = 1'b1;
        cycle();
        bus.start  = 1'b0;
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_ready", 32'(bus.step_ready), 32'd1);
        check("start_steps", 32'(bus.step_count), 32'd0);
        check("start_reward", 32'(bus.reward), 32'd0);
        check("start_cause", 32'(bus.done_cause), 32'd0);
    endtask

    // Check the DONE sample and the two following cycles.
    task automatic finish_episode();
        check("done_latency", 32'(bus.episode_done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("done_ready", 32'(bus.step_ready), 32'd0);
        cycle();
        check("restart_agent_reset", 32'(bus.agent_reset), 32'd1);
        check("restart_steps", 32'(bus.step_count), 32'd0);
        check("restart_reward", 32'(bus.reward), 32'd0);
        check("restart_ready", 32'(bus.step_ready), 32'd0);
        check("restart_busy", 32'(bus.busy), 32'd1);
        cycle();
        check("after_restart_ready", 32'(bus.step_ready), 32'(bus.auto_restart));
        check("after_restart_busy", 32'(bus.busy), 32'(bus.auto_restart));
        check("after_restart_steps", 32'(bus.step_count), 32'd0);
    endtask

    task automatic run_episode(input vec_t v, input bit do_start);
        if (do_start) start_episode(v.sel);
        exp_q.push_back({v.cause, v.steps, v.rew_exp});
        for (int i = 0; i < v.n; i++)
            drive_step((i == v.n - 1) ? v.last : v.rew);
        bus.step_valid = 1'b0;
        if (v.abort) begin
            repeat (3) cycle();
            check("no_early_done", 32'(bus.episode_done), 32'd0);
            bus.abort = 1'b1;
            cycle();
            bus.abort = 1'b0;
        end
        finish_episode();
    endtask

    initial begin
        //            sel n   rew   last   ab  cause  steps rew_exp
        tbl[0] = '{1'b1, 25, 10'd5,    10'd5,    1'b0, LIMIT, 5'd25, 10'd5};
        tbl[1] = '{1'b0, 6,  10'd100,  10'd1023, 1'b0, GOAL,  5'd6,  10'd1023};
        tbl[2] = '{1'b0, 1,  10'd0,    10'd1023, 1'b0, GOAL,  5'd1,  10'd1023};
        tbl[3] = '{1'b1, 25, 10'd1023, 10'd1023, 1'b0, LIMIT, 5'd25, 10'd1023};
        tbl[4] = '{1'b1, 3,  10'd9,    10'd9,    1'b1, ABORT, 5'd3,  10'd9};
        tbl[5] = '{1'b0, 0,  10'd0,    10'd0,    1'b1, ABORT, 5'd0,  10'd0};
        tbl[6] = '{1'b0, 40, 10'd0,    10'd0,    1'b1, ABORT, 5'd31, 10'd0};
        tbl[7] = '{1'b0, 33, 10'd2,    10'd1023, 1'b0, GOAL,  5'd31, 10'd1023};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.select = 1'b0; bus.auto_restart = 1'b0;
        bus.abort = 1'b0; bus.step_valid = 1'b0; bus.reward_in = '0;
        bus2.start = 1'b0; bus2.select = 1'b0; bus2.auto_restart = 1'b0;
        bus2.abort = 1'b0; bus2.step_valid = 1'b0; bus2.reward_in = '0;
        repeat (3) cycle();
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_ready", 32'(bus.step_ready), 32'd0);
        check("rst_steps", 32'(bus.step_count), 32'd0);
        check("rst_reward", 32'(bus.reward), 32'd0);
        check("rst_done", 32'(bus.episode_done), 32'd0);
        check("rst_cause", 32'(bus.done_cause), 32'd0);
        check("rst_agent_reset", 32'(bus.agent_reset), 32'd0);
        check("rst_episodes", 32'(bus.episode_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Steps offered in IDLE are ignored.
        bus.step_valid = 1'b1; bus.reward_in = 10'd77;
        repeat (2) cycle();
        check("idle_ignores_step", 32'(bus.step_count), 32'd0);
        check("idle_ready", 32'(bus.step_ready), 32'd0);
        bus.step_valid = 1'b0;

        // Table of whole episodes.
        for (int t = 0; t < 8; t++) run_episode(tbl[t], 1'b1);

        // Goal sequence 3, 7, 1023; start/select toggled mid-episode must not matter.
        start_episode(1'b0);
        exp_q.push_back({GOAL, 5'd3, 10'd1023});
        bus.select = 1'b1;
        bus.start  = 1'b1;
        drive_step(10'd3);
        drive_step(10'd7);
        check("goal_mid_steps", 32'(bus.step_count), 32'd2);
        check("goal_mid_reward", 32'(bus.reward), 32'd7);
        drive_step(10'd1023);
        bus.start = 1'b0;
        // step_valid stays high through DONE and RESTART.
        check("stall_done_ready", 32'(bus.step_ready), 32'd0);
        finish_episode();
        check("stall_idle_steps", 32'(bus.step_count), 32'd0);
        bus.step_valid = 1'b0;

        // Abort together with the step that reaches the limit: limit wins.
        start_episode(1'b1);
        exp_q.push_back({LIMIT, 5'd25, 10'd5});
        for (int i = 0; i < 24; i++) drive_step(10'd1);
        bus.abort = 1'b1;
        drive_step(10'd5);
        bus.abort = 1'b0; bus.step_valid = 1'b0;
        finish_episode();

        // Abort together with a non-terminating step: step kept, abort cause.
        start_episode(1'b0);
        exp_q.push_back({ABORT, 5'd1, 10'd4});
        bus.abort = 1'b1;
        drive_step(10'd4);
        bus.abort = 1'b0; bus.step_valid = 1'b0;
        finish_episode();

        // Mid-episode reset.
        start_episode(1'b1);
        for (int i = 0; i < 10; i++) drive_step(10'd6);
        check("pre_reset_steps", 32'(bus.step_count), 32'd10);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        bus.step_valid = 1'b0;
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        check("mid_rst_steps", 32'(bus.step_count), 32'd0);
        check("mid_rst_reward", 32'(bus.reward), 32'd0);
        check("mid_rst_done", 32'(bus.episode_done), 32'd0);
        check("mid_rst_episodes", 32'(bus.episode_count), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ready", 32'(bus.step_ready), 32'd0);
        ep_model = 0;
        cycle();
        check("mid_rst_no_done", 32'(bus.episode_done), 32'd0);

        // Three step-mode episodes back to back with auto restart.
        for (int e = 0; e < 3; e++) begin
            bus.auto_restart = (e < 2);
            run_episode(tbl[0], e == 0);
        end
        check("auto_episode_count", 32'(bus.episode_count), 32'd3);
        check("auto_final_state", 32'(dbg_state), 32'(IDLE));

        // Episode counter wrap on a 2-bit instance: 1,2,3,0,1.
        begin
            int m2, n2, guard;
            m2 = 0; n2 = 0; guard = 0;
            bus2.select = 1'b0; bus2.auto_restart = 1'b1;
            bus2.step_valid = 1'b1; bus2.reward_in = 10'd1023;
            bus2.start = 1'b1;
            while (n2 < 5 && guard < 60) begin
                cycle();
                bus2.start = 1'b0;
                if (bus2.episode_done) begin
                    m2 = (m2 + 1) % 4;
                    n2++;
                    check("wrap_count", 32'(bus2.episode_count), 32'(m2));
                    if (n2 == 4) check("wrap_to_zero", 32'(bus2.episode_count), 32'd0);
                end
                guard++;
            end
            check("wrap_episodes_seen", 32'(n2), 32'd5);
            bus2.auto_restart = 1'b0; bus2.step_valid = 1'b0;
            repeat (3) cycle();
            check("wrap_final_busy", 32'(bus2.busy), 32'd0);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
